// File: rtl/aud_transport_if.sv
// Transport controller bus: key/switch/codec inputs in, AudDSP/AudRecorder/AudPlayer controls out.
interface aud_transport_if #(
   parameter int ADDR_W  = 20,
   parameter int SPEED_W = 4,
   parameter int TIME_W  = 8
);
   logic               i_key_play, i_key_rec, i_key_stop;
   logic [SPEED_W-1:0] i_speed;
   logic               i_fast, i_slow_0, i_slow_1;
   logic               i_loop;
   logic               i_daclrck, i_adclrck;
   logic               i_i2c_finished;
   logic [ADDR_W-1:0]  i_play_addr, i_rec_addr;
   logic [2:0]         o_state;
   logic               o_i2c_start;
   logic               o_dsp_start, o_dsp_pause, o_dsp_stop;
   logic               o_rec_start, o_rec_pause, o_rec_stop;
   logic               o_player_en;
   logic [SPEED_W-1:0] o_speed;
   logic [2:0]         o_mode;
   logic [ADDR_W-1:0]  o_rec_len;
   logic [TIME_W-1:0]  o_play_sec, o_rec_sec;

   modport slave (
      input  i_key_play, i_key_rec, i_key_stop, i_speed, i_fast, i_slow_0, i_slow_1,
             i_loop, i_daclrck, i_adclrck, i_i2c_finished, i_play_addr, i_rec_addr,
      output o_state, o_i2c_start, o_dsp_start, o_dsp_pause, o_dsp_stop,
             o_rec_start, o_rec_pause, o_rec_stop, o_player_en, o_speed, o_mode,
             o_rec_len, o_play_sec, o_rec_sec
   );

   modport master (
      output i_key_play, i_key_rec, i_key_stop, i_speed, i_fast, i_slow_0, i_slow_1,
             i_loop, i_daclrck, i_adclrck, i_i2c_finished, i_play_addr, i_rec_addr,
      input  o_state, o_i2c_start, o_dsp_start, o_dsp_pause, o_dsp_stop,
             o_rec_start, o_rec_pause, o_rec_stop, o_player_en, o_speed, o_mode,
             o_rec_len, o_play_sec, o_rec_sec
   );
endinterface

// File: rtl/aud_transport_ctrl.sv
// Audio transport FSM: I2C bring-up, record/play/pause/stop arbitration, loop restart,
// recorded-length latch and speed-scaled seconds counters, all on the codec bit clock.
module aud_transport_ctrl #(
   parameter int              ADDR_W        = 20,
   parameter int              SPEED_W       = 4,
   parameter int              MAX_SPEED     = 8,
   parameter int              TICKS_PER_SEC = 12000000,
   parameter int              TIME_W        = 8,
   parameter logic [ADDR_W-1:0] INIT_LEN    = '1
) (
   input logic              i_AUD_BCLK,
   input logic              i_rst_n,
   aud_transport_if.slave   bus
);
   localparam int ACC_W = $clog2(TICKS_PER_SEC + MAX_SPEED);
   localparam logic [ACC_W-1:0] TPS = ACC_W'(TICKS_PER_SEC);

   typedef enum logic [2:0] {
      S_I2C = 3'd0, S_IDLE = 3'd1, S_PLAY = 3'd2, S_PLAY_PAUSE = 3'd3,
      S_REC = 3'd4, S_REC_PAUSE = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic               restart_q, restart_d;
   logic [ADDR_W-1:0]  rec_len_q, rec_len_d;
   logic [ACC_W-1:0]   play_acc_q, play_acc_d, rec_acc_q, rec_acc_d;
   logic [TIME_W-1:0]  play_sec_q, play_sec_d, rec_sec_q, rec_sec_d;
   logic [SPEED_W-1:0] sub_q, sub_d, spd_q, spd;
   logic [ACC_W-1:0]   play_sum, rec_sum, play_inc;
   logic               play_end, tick_slow;

   always_comb begin
      spd = bus.i_speed;
      if (bus.i_speed == '0)                         spd = SPEED_W'(1);
      else if (bus.i_speed > SPEED_W'(MAX_SPEED))    spd = SPEED_W'(MAX_SPEED);
   end

   assign play_end = (bus.i_play_addr >= rec_len_q);

   always_ff @(posedge i_AUD_BCLK or negedge i_rst_n)
      if (!i_rst_n) state_q <= S_I2C;
      else          state_q <= state_d;

   // key_stop first, then end-of-data, then the play/rec toggles
   always_comb begin
      state_d   = state_q;
      restart_d = 1'b0;
      case (state_q)
         S_I2C:  if (bus.i_i2c_finished) state_d = S_IDLE;
         S_IDLE: begin
            if (bus.i_key_rec)                                state_d = S_REC;
            else if (bus.i_key_play && rec_len_q != '0)       state_d = S_PLAY;
         end
         S_PLAY: begin
            if (bus.i_key_stop)        state_d = S_IDLE;
            else if (play_end) begin
               if (bus.i_loop)         restart_d = !restart_q;
               else                    state_d = S_IDLE;
            end
            else if (bus.i_key_play)   state_d = S_PLAY_PAUSE;
         end
         S_PLAY_PAUSE: begin
            if (bus.i_key_stop)        state_d = S_IDLE;
            else if (bus.i_key_play)   state_d = S_PLAY;
         end
         S_REC: begin
            if (bus.i_key_stop)              state_d = S_IDLE;
            else if (bus.i_rec_addr == '1)   state_d = S_IDLE;
            else if (bus.i_key_rec)          state_d = S_REC_PAUSE;
         end
         S_REC_PAUSE: begin
            if (bus.i_key_stop)        state_d = S_IDLE;
            else if (bus.i_key_rec)    state_d = S_REC;
         end
         default: state_d = S_I2C;
      endcase
   end

   always_comb begin
      bus.o_state     = state_q;
      bus.o_i2c_start = (state_q == S_I2C);
      bus.o_dsp_start = (state_q == S_PLAY) && !bus.i_daclrck;
      bus.o_dsp_pause = (state_q == S_PLAY_PAUSE) && !bus.i_daclrck;
      bus.o_dsp_stop  = (state_q == S_IDLE) || restart_q;
      bus.o_player_en = (state_q == S_PLAY) && !restart_q;
      bus.o_rec_start = (state_q == S_REC) && bus.i_adclrck;
      bus.o_rec_pause = (state_q == S_REC_PAUSE) && !bus.i_adclrck;
      bus.o_rec_stop  = (state_q == S_IDLE);
      bus.o_speed     = spd;
      bus.o_mode      = bus.i_fast ? 3'b100 : (bus.i_slow_0 ? 3'b010 : 3'b001);
      bus.o_rec_len   = rec_len_q;
      bus.o_play_sec  = play_sec_q;
      bus.o_rec_sec   = rec_sec_q;
   end

   always_comb begin
      rec_len_d = rec_len_q;
      if ((state_q == S_REC || state_q == S_REC_PAUSE) && state_d == S_IDLE)
         rec_len_d = bus.i_rec_addr;
   end

   // Slow modes feed one tick every o_speed cycles via sub_q; fast adds o_speed per cycle
   always_comb begin
      play_acc_d = play_acc_q;
      play_sec_d = play_sec_q;
      sub_d      = sub_q;
      tick_slow  = (sub_q >= spd);
      play_inc   = bus.i_fast ? ACC_W'(spd) : ACC_W'(tick_slow);
      play_sum   = play_acc_q + play_inc;
      if (state_q == S_PLAY && !restart_q) begin
         if (!bus.i_fast) sub_d = tick_slow ? SPEED_W'(1) : sub_q + SPEED_W'(1);
         if (play_sum >= TPS) begin
            play_acc_d = play_sum - TPS;
            if (play_sec_q != '1) play_sec_d = play_sec_q + TIME_W'(1);
         end else
            play_acc_d = play_sum;
      end
      if (spd != spd_q) sub_d = SPEED_W'(1);
      if (state_d == S_IDLE || restart_d) begin
         play_acc_d = '0;
         play_sec_d = '0;
      end
   end

   always_comb begin
      rec_acc_d = rec_acc_q;
      rec_sec_d = rec_sec_q;
      rec_sum   = rec_acc_q + ACC_W'(1);
      if (state_q == S_IDLE && state_d == S_REC) begin
         rec_acc_d = '0;
         rec_sec_d = '0;
      end else if (state_q == S_REC) begin
         if (rec_sum >= TPS) begin
            rec_acc_d = rec_sum - TPS;
            if (rec_sec_q != '1) rec_sec_d = rec_sec_q + TIME_W'(1);
         end else
            rec_acc_d = rec_sum;
      end
   end

   always_ff @(posedge i_AUD_BCLK or negedge i_rst_n)
      if (!i_rst_n) begin
         restart_q  <= 1'b0;
         rec_len_q  <= INIT_LEN;
         play_acc_q <= '0;
         play_sec_q <= '0;
         rec_acc_q  <= '0;
         rec_sec_q  <= '0;
         sub_q      <= SPEED_W'(1);
         spd_q      <= SPEED_W'(1);
      end else begin
         restart_q  <= restart_d;
         rec_len_q  <= rec_len_d;
         play_acc_q <= play_acc_d;
         play_sec_q <= play_sec_d;
         rec_acc_q  <= rec_acc_d;
         rec_sec_q  <= rec_sec_d;
         sub_q      <= sub_d;
         spd_q      <= spd;
      end
endmodule

// File: doc/aud_transport_ctrl.md
# aud_transport_ctrl

Parametrised transport controller for the audio path, clocked on the codec bit clock. It sequences WM8731 I2C bring-up, then arbitrates record, play, pause and stop between AudRecorder and AudDSP/AudPlayer. It also latches recorded length, supports loop playback with auto-stop at end of data, and keeps seconds counters for play and record that scale with playback speed. It sits between the board keys/switches and the I2cInitializer, AudDSP, AudPlayer and AudRecorder instances.

## Interface
- ADDR_W, 20: sample address width.
- SPEED_W, 4: width of speed input.
- MAX_SPEED, 8: speed saturation value (1..2^SPEED_W-1).
- TICKS_PER_SEC, 12000000: i_AUD_BCLK cycles per second of 1x audio.
- TIME_W, 8: seconds counter width; saturates at all-ones.
- INIT_LEN, 2^ADDR_W-1: play length after reset (pre-loaded memory).

Ports:
- i_AUD_BCLK  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_key_play, i_key_rec, i_key_stop  in  1 each  debounced one-cycle pulses, synchronous to i_AUD_BCLK.
- i_speed  in  SPEED_W  requested speed factor.
- i_fast, i_slow_0, i_slow_1  in  1 each  mode switches.
- i_loop  in  1  loop playback enable.
- i_daclrck, i_adclrck  in  1 each  codec LR clocks.
- i_i2c_finished  in  1  I2cInitializer done (level).
- i_play_addr  in  ADDR_W  current AudDSP address.
- i_rec_addr  in  ADDR_W  current AudRecorder address.
- o_state  out  3  current state encoding.
- o_i2c_start  out  1  I2C init enable.
- o_dsp_start, o_dsp_pause, o_dsp_stop  out  1 each  AudDSP controls.
- o_rec_start, o_rec_pause, o_rec_stop  out  1 each  AudRecorder controls.
- o_player_en  out  1  AudPlayer enable.
- o_speed  out  SPEED_W  sanitised speed.
- o_mode  out  3  one-hot {fast, slow_0, slow_1}.
- o_rec_len  out  ADDR_W  last valid sample address.
- o_play_sec, o_rec_sec  out  TIME_W each  elapsed seconds.

## Operation
- States: S_I2C=0, S_IDLE=1, S_PLAY=2, S_PLAY_PAUSE=3, S_REC=4, S_REC_PAUSE=5. Reset state is S_I2C.
- Transitions:
  - S_I2C->S_IDLE when i_i2c_finished. All keys are ignored in S_I2C.
  - S_IDLE: key_rec->S_REC; key_play->S_PLAY only if o_rec_len!=0. If both keys arrive together, key_rec wins.
  - S_PLAY: key_play->S_PLAY_PAUSE. S_PLAY_PAUSE: key_play->S_PLAY.
  - S_REC: key_rec->S_REC_PAUSE. S_REC_PAUSE: key_rec->S_REC.
  - key_stop in any PLAY/REC state->S_IDLE. key_stop has priority over every other key.
- End handling:
  - In S_PLAY with i_play_addr>=o_rec_len and i_loop=1: the state is held, a one-cycle restart pulse is raised, and play counters clear.
  - Same condition with i_loop=0: go to S_IDLE.
  - In S_REC with i_rec_addr == 2^ADDR_W-1: go to S_IDLE.
  - End takes priority over key_play/key_rec in the same cycle. key_stop still wins.
- o_rec_len is loaded with i_rec_addr on every exit from S_REC or S_REC_PAUSE to S_IDLE. Reset value is INIT_LEN.
- o_speed: i_speed==0 gives 1; i_speed>MAX_SPEED gives MAX_SPEED; otherwise i_speed.
- o_mode priority: i_fast (100) > i_slow_0 (010) > default 001.
- Output decode from registered state:
  - o_i2c_start=(S_I2C).
  - o_dsp_start=(S_PLAY & !i_daclrck).
  - o_dsp_pause=(S_PLAY_PAUSE & !i_daclrck).
  - o_dsp_stop=(S_IDLE | restart pulse).
  - o_player_en=(S_PLAY & !restart).
  - o_rec_start=(S_REC & i_adclrck).
  - o_rec_pause=(S_REC_PAUSE & !i_adclrck).
  - o_rec_stop=(S_IDLE).
- Play time:
  - Tick accumulator is ceil(log2(TICKS_PER_SEC+MAX_SPEED)) bits.
  - Fast mode: add o_speed per cycle.
  - Slow modes: add 1 every o_speed cycles, using a sub-counter that runs 1..o_speed.
  - Reaching >=TICKS_PER_SEC subtracts TICKS_PER_SEC, keeps the remainder, and increments o_play_sec (saturating).
  - Held in pause. Cleared on entry to S_IDLE and on loop restart.
- Record time: add 1 per cycle in S_REC only; same wrap rule. o_rec_sec clears on S_IDLE->S_REC and is retained otherwise.

## Timing
- Keys and end conditions are sampled on the posedge. The state updates at that edge; decoded outputs follow it combinationally. Key-to-output latency is 1 cycle.
- The restart pulse is registered and lasts exactly 1 cycle. S_PLAY playback resumes on the next cycle.
- Speed or mode changes take effect on the next tick. The sub-counter resets to 1 when o_speed changes.
- Async reset values:
  - state=S_I2C, so o_i2c_start=1 and all other controls are 0.
  - o_state=0.
  - o_rec_len=INIT_LEN.
  - o_play_sec=0, o_rec_sec=0.
  - Accumulators are 0; the sub-counter is 1.
- Reset mid-play or mid-record aborts immediately. o_rec_len returns to INIT_LEN and does not keep the partial length.
- The seconds counters saturate at 2^TIME_W-1 and never wrap.

## Test plan
- Bring-up: reset, then i_i2c_finished pulse after 5 cycles -> o_i2c_start=1 until S_IDLE, and key_play during S_I2C is ignored.
- Record/stop: TICKS_PER_SEC=10, key_rec, then 35 cycles, then key_stop with i_rec_addr=0x123 -> o_rec_sec=3 and o_rec_len=0x123.
- Speed scaling: TICKS_PER_SEC=10, fast, i_speed=4, play 25 cycles -> o_play_sec=10. Slow_1 with i_speed=0, 20 cycles -> o_play_sec=2, o_speed=1.
- Loop: i_loop=1, i_play_addr driven to o_rec_len -> a single 1-cycle o_dsp_stop, state stays 2, o_play_sec=0. With i_loop=0 -> state 1.
- Priority: key_stop and key_play in the same cycle in S_PLAY -> S_IDLE. End and key_play in the same cycle -> loop restart, not pause.
- Pause gating: in S_PLAY_PAUSE toggle i_daclrck -> o_dsp_pause follows !i_daclrck, o_play_sec holds, o_player_en=0.
